neuron_feeder: RTL and testbench

- Sequencer that drives the weight/data/clear/en side of one Q16.16 neuron accumulator and collects its result.
- On `start`: clears the neuron, then streams N_INPUTS weight/data pairs from two synchronous-read memories. It then waits for the final accumulation, captures `accum`, applies an optional ReLU, and presents the result on a valid/ready output.
- Sits between the layer's weight/activation RAMs and each neuron instance.

---
 rtl/neuron_feeder.sv | 181 ++++++++++++++++++
 tb/tb_neuron_feeder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_feeder.sv
// Sequencer that clears one Q16.16 neuron, streams weight/data pairs from two
// synchronous-read memories into it, then captures and presents the result.
module neuron_feeder #(
  parameter int N_INPUTS = 784,
  parameter int ADDR_W   = 10,
  parameter int RELU     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       w_rdata_i,
  input  logic [31:0]       d_rdata_i,
  output logic              n_clear_o,
  output logic              n_en_o,
  output logic [31:0]       n_weight_o,
  output logic [31:0]       n_data_o,
  input  logic [31:0]       n_accum_i,
  output logic [31:0]       result_o,
  output logic              result_valid_o,
  input  logic              result_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic              clear_q, clear_d;
  logic [31:0]       result_q, result_d;
  logic              valid_q, valid_d;
  logic              mem_vld_q;
  logic              en_q;
  logic [31:0]       weight_q;
  logic [31:0]       data_q;

  function automatic logic [31:0] relu_f(input logic [31:0] a);
    if ((RELU != 0) && a[31]) begin
      return 32'h0000_0000;
    end else begin
      return a;
    end
  endfunction

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en_d  = 1'b0;
    clear_d  = 1'b0;
    result_d = result_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          busy_d  = 1'b1;
          clear_d = 1'b1;
          rd_en_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CLEAR: begin
        if (N_INPUTS == 1) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
          idx_d   = idx_q + ONE;
          addr_d  = idx_q + ONE;
          rd_en_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          idx_d   = idx_q + ONE;
          addr_d  = idx_q + ONE;
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // Both pipeline stages empty means n_accum already includes the last pair.
        if (!mem_vld_q && !en_q) begin
          state_d  = S_OUT;
          result_d = relu_f(n_accum_i);
          valid_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_OUT: begin
        if (result_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Control state and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      clear_q  <= 1'b0;
      result_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      clear_q  <= clear_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Read pipeline: memory latency stage, then operand registers zeroed when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_vld_q <= 1'b0;
      en_q      <= 1'b0;
      weight_q  <= 32'h0000_0000;
      data_q    <= 32'h0000_0000;
    end else begin
      mem_vld_q <= rd_en_q;
      en_q      <= mem_vld_q;
      weight_q  <= mem_vld_q ? w_rdata_i : 32'h0000_0000;
      data_q    <= mem_vld_q ? d_rdata_i : 32'h0000_0000;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mem_rd_en_o    = rd_en_q;
  assign mem_addr_o     = addr_q;
  assign n_clear_o      = clear_q;
  assign n_en_o         = en_q;
  assign n_weight_o     = weight_q;
  assign n_data_o       = data_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: a cycle-schedule model checks the main instance every
// cycle; directed runs pin results, latencies, ReLU variants and N_INPUTS=1.
module tb_neuron_feeder;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main instance (N=4, RELU=1) with bench memories and a real neuron
  logic        start_s = 1'b0, ready_s = 1'b0;
  logic        busy, done, rd_en, n_clear, n_en, res_valid;
  logic [1:0]  addr;
  logic [31:0] w_rdata = 32'h0, d_rdata = 32'h0;
  logic [31:0] n_weight, n_data, n_accum, result;
  logic [31:0] w_mem [N];
  logic [31:0] d_mem [N];
  logic [31:0] acc = 32'h0;
  bit          stub = 1'b0;

  neuron_feeder #(.N_INPUTS(N), .ADDR_W(2), .RELU(1)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_s), .busy_o(busy), .done_o(done),
    .mem_rd_en_o(rd_en), .mem_addr_o(addr), .w_rdata_i(w_rdata), .d_rdata_i(d_rdata),
    .n_clear_o(n_clear), .n_en_o(n_en), .n_weight_o(n_weight), .n_data_o(n_data),
    .n_accum_i(n_accum), .result_o(result), .result_valid_o(res_valid),
    .result_ready_i(ready_s)
  );

  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p[47:16];
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      w_rdata <= w_mem[addr];
      d_rdata <= d_mem[addr];
    end
  end

  always @(posedge clk) begin
    if (n_clear) acc <= 32'h0;
    else if (n_en) acc <= acc + qmul(n_weight, n_data);
  end

  assign n_accum = stub ? 32'hFFF8_0000 : acc;

  // Auxiliary instances: [0] N=4 RELU=0 with stub accumulator, [1] N=1 RELU=1
  logic [1:0]  ast = 2'b00;
  logic [1:0]  av, abusy, adone, ard, aclr, aen;
  logic [31:0] ares [2];
  logic [31:0] aw [2];
  logic [31:0] ad [2];
  logic [1:0]  a0_addr;
  logic [0:0]  a1_addr;
  logic        aux_rdy = 1'b1;
  logic [31:0] zero32 = 32'h0, stub32 = 32'hFFF8_0000;
  logic [31:0] o_w = 32'h0, o_d = 32'h0, o_acc = 32'h0;

  neuron_feeder #(.N_INPUTS(4), .ADDR_W(2), .RELU(0)) u_nr (
    .clk(clk), .rst(rst), .start_i(ast[0]), .busy_o(abusy[0]), .done_o(adone[0]),
    .mem_rd_en_o(ard[0]), .mem_addr_o(a0_addr), .w_rdata_i(zero32), .d_rdata_i(zero32),
    .n_clear_o(aclr[0]), .n_en_o(aen[0]), .n_weight_o(aw[0]), .n_data_o(ad[0]),
    .n_accum_i(stub32), .result_o(ares[0]), .result_valid_o(av[0]),
    .result_ready_i(aux_rdy)
  );

  neuron_feeder #(.N_INPUTS(1), .ADDR_W(1), .RELU(1)) u_one (
    .clk(clk), .rst(rst), .start_i(ast[1]), .busy_o(abusy[1]), .done_o(adone[1]),
    .mem_rd_en_o(ard[1]), .mem_addr_o(a1_addr), .w_rdata_i(o_w), .d_rdata_i(o_d),
    .n_clear_o(aclr[1]), .n_en_o(aen[1]), .n_weight_o(aw[1]), .n_data_o(ad[1]),
    .n_accum_i(o_acc), .result_o(ares[1]), .result_valid_o(av[1]),
    .result_ready_i(aux_rdy)
  );

  always @(posedge clk) begin
    if (ard[1] && a1_addr == 1'b0) begin
      o_w <= 32'h0003_0000;
      o_d <= 32'h0001_0000;
    end
    if (aclr[1]) o_acc <= 32'h0;
    else if (aen[1]) o_acc <= o_acc + qmul(aw[1], ad[1]);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: position k within an evaluation fixes every output
  bit          m_act = 1'b0, m_valid = 1'b0, m_done = 1'b0;
  int          m_k = 0;
  logic [31:0] m_res = 32'h0;

  function automatic logic [31:0] m_relu(input logic [31:0] a);
    return a[31] ? 32'h0 : a;
  endfunction

  function automatic logic [31:0] m_expect();
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < N; i++) s = s + qmul(w_mem[i], d_mem[i]);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act   <= 1'b0;
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      m_k     <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_valid && ready_s) begin
        m_valid <= 1'b0;
        m_act   <= 1'b0;
        m_done  <= 1'b1;
      end else if (!m_act && start_s) begin
        m_act <= 1'b1;
        m_k   <= 1;
        m_res <= stub ? m_relu(32'hFFF8_0000) : m_relu(m_expect());
      end else if (m_act) begin
        m_k <= m_k + 1;
        if (m_k + 1 == N + 4) m_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit rde, ene;
    int ix;
    rde = m_act && m_k >= 1 && m_k <= N;
    ene = m_act && m_k >= 3 && m_k <= N + 2;
    ix  = ene ? m_k - 3 : 0;
    cmp("busy", busy, m_act);
    cmp("n_clear", n_clear, m_act && m_k == 1);
    cmp("mem_rd_en", rd_en, rde);
    cmp("mem_addr", addr, rde ? m_k - 1 : 0);
    cmp("n_en", n_en, ene);
    cmp("n_weight", n_weight, ene ? w_mem[ix] : 32'h0);
    cmp("n_data", n_data, ene ? d_mem[ix] : 32'h0);
    cmp("clear_en_overlap", n_clear & n_en, 1'b0);
    cmp("result_valid", res_valid, m_valid);
    if (m_valid) cmp("result", result, m_res);
    cmp("done", done, m_done);
  end

  task automatic run_eval(input int hold, input int stray, input bit chain,
                          output int vk, output int dk, output logic [31:0] r,
                          output int en_cnt, output int n_done);
    int k, vcnt;
    bit seen;
    vk = 0; dk = 0; r = 32'h0; en_cnt = 0; n_done = 0; vcnt = 0; seen = 1'b0;
    start_s = 1'b1;
    ready_s = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b0;
    k = 1;
    while (k < 60) begin
      start_s = (k == stray);
      if (res_valid) begin
        vcnt++;
        if (!seen) begin seen = 1'b1; vk = k; r = result; end
      end
      ready_s = res_valid && (vcnt > hold);
      if (n_en) en_cnt++;
      if (done) begin
        n_done++;
        if (dk == 0) dk = k;
        if (chain) break;
      end
      if (dk != 0 && k >= dk + 2) break;
      @(posedge clk); #1;
      k++;
    end
    start_s = 1'b0;
    ready_s = 1'b0;
    cmp("eval_completed", dk != 0, 1'b1);
  endtask

  task automatic aux(input int sel, output int vk, output logic [31:0] r);
    int k;
    vk = 0; r = 32'h0;
    ast[sel] = 1'b1;
    @(posedge clk); #1;
    ast[sel] = 1'b0;
    k = 1;
    while (k < 40 && vk == 0) begin
      if (av[sel]) begin
        vk = k;
        r  = ares[sel];
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vk, dk, en, nd;
    logic [31:0] r, r1;
    for (int i = 0; i < N; i++) begin
      w_mem[i] = 32'h0001_0000;
      d_mem[i] = 32'(i + 1) << 16;
    end
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_busy", busy, 1'b0);
    cmp("rst_valid", res_valid, 1'b0);
    cmp("rst_result", result, 32'h0);
    cmp("rst_rd_en", rd_en, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic stream: 1+2+3+4 = 10.0
    run_eval(0, 0, 1'b0, vk, dk, r, en, nd);
    cmp("basic_result", r, 32'h000A_0000);
    cmp("basic_valid_cycle", vk, 8);
    cmp("basic_done_cycle", dk, 9);
    cmp("basic_en_count", en, 4);
    cmp("basic_done_count", nd, 1);

    // Backpressure: ready low for 5 valid cycles
    run_eval(5, 0, 1'b0, vk, dk, r, en, nd);
    cmp("bp_result", r, 32'h000A_0000);
    cmp("bp_valid_cycle", vk, 8);
    cmp("bp_done_cycle", dk, 14);
    cmp("bp_done_count", nd, 1);

    // ReLU clamps a negative accumulator
    stub = 1'b1;
    run_eval(0, 0, 1'b0, vk, dk, r, en, nd);
    cmp("relu_result", r, 32'h0);
    stub = 1'b0;

    // Back-to-back evaluations must not carry the accumulator over
    for (int i = 0; i < N; i++) begin
      w_mem[i] = 32'h0002_0000;
      d_mem[i] = 32'h0001_0000;
    end
    run_eval(0, 0, 1'b1, vk, dk, r1, en, nd);
    run_eval(0, 0, 1'b0, vk, dk, r, en, nd);
    cmp("b2b_first", r1, 32'h0008_0000);
    cmp("b2b_second", r, 32'h0008_0000);
    cmp("b2b_second_valid_cycle", vk, 8);

    // Start during STREAM is ignored
    run_eval(0, 3, 1'b0, vk, dk, r, en, nd);
    cmp("stray_done_count", nd, 1);
    cmp("stray_result", r, 32'h0008_0000);

    // Reset mid-stream
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    cmp("midrst_busy", busy, 1'b0);
    cmp("midrst_rd_en", rd_en, 1'b0);
    cmp("midrst_addr", addr, 2'b00);
    cmp("midrst_n_en", n_en, 1'b0);
    cmp("midrst_weight", n_weight, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    cmp("midrst_no_done", nd, 0);
    run_eval(0, 0, 1'b0, vk, dk, r, en, nd);
    cmp("postrst_result", r, 32'h0008_0000);
    cmp("postrst_valid_cycle", vk, 8);

    // RELU=0 passes the negative value through
    aux(0, vk, r);
    cmp("norelu_result", r, 32'hFFF8_0000);
    cmp("norelu_valid_cycle", vk, 8);

    // N_INPUTS=1 skips STREAM
    aux(1, vk, r);
    cmp("n1_result", r, 32'h0003_0000);
    cmp("n1_valid_cycle", vk, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
